// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, DATA_W data bits LSB-first,
// optional parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        serial_d  = 1'b1;
        bit_end   = (clk_cnt_q == CLK_LAST);

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = (^tx_data) ^ (PARITY == 2);
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line is registered, so it is derived from where the FSM lands next.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PAR:     serial_d = parity_d;
            default: serial_d = 1'b1;
        endcase
    end

    assign tx_serial = serial_q;
    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed self-checking bench for serial_tx; four instances cover no parity,
// even parity, odd parity and the DATA_W=1 / CLKS_PER_BIT=1 corner.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid;
    logic [7:0] data [4];
    wire  [3:0] serial;
    wire  [3:0] ready;
    wire  [3:0] busy;
    wire  [3:0] done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0)) u0 (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_serial(serial[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_serial(serial[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_serial(serial[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY(0)) u3 (
        .clk(clk), .rst(rst), .tx_data(data[3][0:0]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_serial(serial[3]), .tx_busy(busy[3]), .tx_done(done[3])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int u, input logic v, input logic [7:0] d);
        valid[u] = v;
        data[u]  = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; walks the whole frame, then checks
    // the tx_done cycle. pokeAt >= 0 injects a new word mid-frame.
    task automatic expectFrame(input int u, input logic [7:0] word, input int dw,
                               input int cpb, input int par, input int pokeAt);
        logic [15:0] bits;
        logic        p;
        int          nb;
        p = 1'b0;
        for (int i = 0; i < dw; i++) p = p ^ word[i];
        if (par == 2) p = ~p;
        bits = '0;
        for (int i = 0; i < dw; i++) bits[i+1] = word[i];
        nb = dw + 2;
        if (par != 0) begin
            bits[dw+1] = p;
            nb++;
        end
        bits[nb-1] = 1'b1;
        for (int k = 0; k < nb * cpb; k++) begin
            checkOutput($sformatf("u%0d line c%0d", u, k), 32'(serial[u]), 32'(bits[k / cpb]));
            checkOutput($sformatf("u%0d busy c%0d", u, k), 32'(busy[u]), 32'd1);
            checkOutput($sformatf("u%0d ready c%0d", u, k), 32'(ready[u]), 32'd0);
            checkOutput($sformatf("u%0d done c%0d", u, k), 32'(done[u]), 32'd0);
            if (pokeAt >= 0 && k == pokeAt) applyStimulus(u, 1'b1, 8'h3C);
            else if (pokeAt >= 0 && k == pokeAt + 1) valid[u] = 1'b0;
            tick();
        end
        checkOutput($sformatf("u%0d done pulse", u), 32'(done[u]), 32'd1);
        checkOutput($sformatf("u%0d ready back", u), 32'(ready[u]), 32'd1);
        checkOutput($sformatf("u%0d busy clear", u), 32'(busy[u]), 32'd0);
        checkOutput($sformatf("u%0d idle line", u), 32'(serial[u]), 32'd1);
    endtask

    initial begin
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        rst = 1'b1;
        repeat (2) tick();
        for (int u = 0; u < 4; u++) begin
            checkOutput($sformatf("u%0d reset line", u), 32'(serial[u]), 32'd1);
            checkOutput($sformatf("u%0d reset ready", u), 32'(ready[u]), 32'd1);
            checkOutput($sformatf("u%0d reset busy", u), 32'(busy[u]), 32'd0);
            checkOutput($sformatf("u%0d reset done", u), 32'(done[u]), 32'd0);
        end
        rst = 1'b0;
        tick();

        $display("[TB] basic frame 0xA5");
        applyStimulus(0, 1'b1, 8'hA5);
        tick();
        valid[0] = 1'b0;
        expectFrame(0, 8'hA5, 8, 4, 0, -1);
        tick();
        checkOutput("u0 done one cycle", 32'(done[0]), 32'd0);

        $display("[TB] even and odd parity 0xA5");
        applyStimulus(1, 1'b1, 8'hA5);
        tick();
        valid[1] = 1'b0;
        expectFrame(1, 8'hA5, 8, 4, 1, -1);
        applyStimulus(2, 1'b1, 8'hA5);
        tick();
        valid[2] = 1'b0;
        expectFrame(2, 8'hA5, 8, 4, 2, -1);
        tick();

        $display("[TB] back-to-back 0x01 then 0xFF");
        applyStimulus(0, 1'b1, 8'h01);
        tick();
        data[0] = 8'hFF;
        expectFrame(0, 8'h01, 8, 4, 0, -1);
        tick();
        valid[0] = 1'b0;
        expectFrame(0, 8'hFF, 8, 4, 0, -1);
        tick();

        $display("[TB] inputs ignored while busy");
        applyStimulus(0, 1'b1, 8'hA5);
        tick();
        valid[0] = 1'b0;
        expectFrame(0, 8'hA5, 8, 4, 0, 10);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("u0 no extra frame %0d", i), 32'(busy[0]), 32'd0);
            checkOutput($sformatf("u0 no extra line %0d", i), 32'(serial[0]), 32'd1);
        end

        $display("[TB] reset mid-frame");
        applyStimulus(0, 1'b1, 8'hA5);
        tick();
        valid[0] = 1'b0;
        repeat (17) tick();
        checkOutput("u0 data bit3 before reset", 32'(serial[0]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("u0 async reset line", 32'(serial[0]), 32'd1);
        checkOutput("u0 async reset ready", 32'(ready[0]), 32'd1);
        checkOutput("u0 async reset busy", 32'(busy[0]), 32'd0);
        checkOutput("u0 async reset done", 32'(done[0]), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("u0 abandoned frame", 32'(serial[0]), 32'd1);
        applyStimulus(0, 1'b1, 8'h5A);
        tick();
        valid[0] = 1'b0;
        expectFrame(0, 8'h5A, 8, 4, 0, -1);

        $display("[TB] corner DATA_W=1 CLKS_PER_BIT=1");
        applyStimulus(3, 1'b1, 8'h01);
        tick();
        valid[3] = 1'b0;
        expectFrame(3, 8'h01, 1, 1, 0, -1);
        tick();
        checkOutput("u3 done one cycle", 32'(done[3]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
